// File: rtl/eth_pkg.sv
// Shared Ethernet/UDP datapath definitions: bus widths, converter state type
// and the tkeep decode used by the 32-to-8 unpacker.
package eth_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } conv_state_t;

    typedef struct packed {
        logic [1:0] last_idx;
        logic       err;
    } keep_dec_t;

    // ord[0] is the first lane sent; the byte count stops at the first hole.
    function automatic keep_dec_t keep_to_last_idx(input logic [3:0] keep,
                                                   input logic       big_endian);
        keep_dec_t  r;
        logic [3:0] ord;
        logic [2:0] n;
        logic       stop;
        ord   = big_endian ? {keep[0], keep[1], keep[2], keep[3]} : keep;
        n     = 3'd0;
        stop  = 1'b0;
        r.err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ord[i] && !stop) begin
                n = n + 3'd1;
            end else if (ord[i]) begin
                r.err = 1'b1;
            end else begin
                stop = 1'b1;
            end
        end
        if (n == 3'd0) begin
            r.last_idx = 2'd0;
            r.err      = 1'b1;
        end else begin
            r.last_idx = 2'(n - 3'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_32_8.sv
// Unpacks 32-bit AXI-Stream words into the byte-wide UDP TX stream,
// one byte per cycle, honouring tkeep on the final word of a packet.
//
// state | meaning
// IDLE  | holding register empty, ready for a word
// SHIFT | holding register loaded, presenting byte idx
module conv_32_8
    import eth_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [WORD_W-1:0] s_axis_tdata,
    input  logic [3:0]        s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [BYTE_W-1:0] data_out,
    output logic              udp_data_valid,
    output logic              udp_data_last,
    input  logic              udp_data_ready,
    output logic              protocol_err
);

    conv_state_t       state;
    conv_state_t       state_nxt;
    logic [WORD_W-1:0] word_buf;
    logic [1:0]        idx;
    logic [1:0]        last_idx;
    logic              pkt_last;

    keep_dec_t         keep_dec;
    logic              on_last;
    logic              accept;
    logic              consume;
    logic [1:0]        lane;

    assign keep_dec = keep_to_last_idx(s_axis_tkeep, BIG_ENDIAN);
    assign on_last  = (idx == last_idx);
    assign accept   = s_axis_tvalid & s_axis_tready;
    assign consume  = (state == SHIFT) & udp_data_ready;

    // Big-endian walks lanes 3..0, little-endian 0..3.
    assign lane     = BIG_ENDIAN ? ~idx : idx;
    assign data_out = word_buf[{lane, 3'b000} +: BYTE_W];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (consume && on_last && !accept) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready  = 1'b0;
        udp_data_valid = 1'b0;
        udp_data_last  = 1'b0;
        case (state)
            IDLE: begin
                s_axis_tready = 1'b1;
            end
            SHIFT: begin
                udp_data_valid = 1'b1;
                udp_data_last  = pkt_last & on_last;
                s_axis_tready  = on_last & udp_data_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            word_buf     <= '0;
            idx          <= 2'd0;
            last_idx     <= 2'd0;
            pkt_last     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (accept) begin
                word_buf <= s_axis_tdata;
                idx      <= 2'd0;
                pkt_last <= s_axis_tlast;
                last_idx <= s_axis_tlast ? keep_dec.last_idx : 2'd3;
                if (s_axis_tlast && keep_dec.err) begin
                    protocol_err <= 1'b1;
                end
            end else if (consume && !on_last) begin
                idx <= idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_conv_32_8.sv
// Directed bench for conv_32_8: one big-endian and one little-endian instance,
// expected bytes queued at stimulus time and checked by per-instance monitors.
module tb_conv_32_8;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] tdata = '0;
    logic [3:0]  tkeep = '0;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic        sel = 1'b0;
    logic        udp_ready = 1'b1;

    logic        tready_be, valid_be, last_be, err_be;
    logic [7:0]  dout_be;
    logic        tready_le, valid_le, last_le, err_le;
    logic [7:0]  dout_le;

    int n_checks = 0;
    int n_fail = 0;

    logic [8:0] q_be[$];
    logic [8:0] q_le[$];

    always #5 aclk = ~aclk;

    conv_32_8 #(.BIG_ENDIAN(1'b1)) dut_be (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
        .s_axis_tvalid(tvalid & ~sel), .s_axis_tready(tready_be),
        .data_out(dout_be), .udp_data_valid(valid_be), .udp_data_last(last_be),
        .udp_data_ready(udp_ready), .protocol_err(err_be)
    );

    conv_32_8 #(.BIG_ENDIAN(1'b0)) dut_le (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
        .s_axis_tvalid(tvalid & sel), .s_axis_tready(tready_le),
        .data_out(dout_le), .udp_data_valid(valid_le), .udp_data_last(last_le),
        .udp_data_ready(udp_ready), .protocol_err(err_le)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Caller is positioned just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic s, input logic [31:0] d, input logic [3:0] k,
                             input logic l, output int waited);
        logic acc;
        sel    = s;
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        tvalid = 1'b1;
        waited = 0;
        acc    = 1'b0;
        while (!acc && waited < 50) begin
            @(negedge aclk);
            acc = s ? tready_le : tready_be;
            @(posedge aclk);
            #1;
            waited++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: word %0h not accepted", d);
        end
    endtask

    task automatic drop();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    always @(negedge aclk) begin
        if (!areset && valid_be && udp_ready) begin
            if (q_be.size() == 0) begin
                check("be_unexpected_byte", {23'd0, last_be, dout_be}, 32'h1ff);
            end else begin
                check("be_byte", {23'd0, last_be, dout_be}, {23'd0, q_be.pop_front()});
            end
        end
        if (!areset && valid_le && udp_ready) begin
            if (q_le.size() == 0) begin
                check("le_unexpected_byte", {23'd0, last_le, dout_le}, 32'h1ff);
            end else begin
                check("le_byte", {23'd0, last_le, dout_le}, {23'd0, q_le.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [7:0] e1 [4];
        e1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

        // reset state
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("rst_valid", {31'd0, valid_be}, 32'd0);
        check("rst_last", {31'd0, last_be}, 32'd0);
        check("rst_data", {24'd0, dout_be}, 32'd0);
        check("rst_err", {31'd0, err_be}, 32'd0);
        @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        check("rel_tready_be", {31'd0, tready_be}, 32'd1);
        check("rel_tready_le", {31'd0, tready_le}, 32'd1);
        check("rel_valid_le", {31'd0, valid_le}, 32'd0);
        @(posedge aclk);
        #1;

        // single full word, latency and tready on the last byte edge
        q_be.push_back({1'b0, 8'hAA});
        q_be.push_back({1'b0, 8'hBB});
        q_be.push_back({1'b0, 8'hCC});
        q_be.push_back({1'b1, 8'hDD});
        send_word(1'b0, 32'hAABBCCDD, 4'b1111, 1'b1, w);
        drop();
        check("t1_accept_wait", w, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            check("t1_valid", {31'd0, valid_be}, 32'd1);
            check("t1_data", {24'd0, dout_be}, {24'd0, e1[k]});
            check("t1_last", {31'd0, last_be}, (k == 3) ? 32'd1 : 32'd0);
            check("t1_tready", {31'd0, tready_be}, (k == 3) ? 32'd1 : 32'd0);
        end
        @(posedge aclk);
        #1;

        // back-to-back words, partial final word, no gap
        q_be.push_back({1'b0, 8'h01});
        q_be.push_back({1'b0, 8'h02});
        q_be.push_back({1'b0, 8'h03});
        q_be.push_back({1'b0, 8'h04});
        q_be.push_back({1'b0, 8'h05});
        q_be.push_back({1'b1, 8'h06});
        send_word(1'b0, 32'h01020304, 4'b1111, 1'b0, w);
        check("t2_w1_wait", w, 1);
        send_word(1'b0, 32'h05060708, 4'b1100, 1'b1, w);
        drop();
        check("t2_w2_wait", w, 4);
        @(negedge aclk);
        check("t2_b4_data", {23'd0, valid_be, dout_be}, 32'h105);
        @(negedge aclk);
        check("t2_b5_data", {22'd0, valid_be, last_be, dout_be}, 32'h306);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        check("t2_idle_after", {31'd0, valid_be}, 32'd0);
        @(posedge aclk);
        #1;

        // back-pressure on byte 2
        q_be.push_back({1'b0, 8'h11});
        q_be.push_back({1'b0, 8'h22});
        q_be.push_back({1'b0, 8'h33});
        q_be.push_back({1'b1, 8'h44});
        send_word(1'b0, 32'h11223344, 4'b1111, 1'b1, w);
        drop();
        @(posedge aclk);
        #1;
        @(posedge aclk);
        #1 udp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            check("t3_hold", {22'd0, valid_be, last_be, dout_be}, 32'h233);
            check("t3_tready_low", {31'd0, tready_be}, 32'd0);
        end
        @(posedge aclk);
        #1 udp_ready = 1'b1;
        @(negedge aclk);
        check("t3_release_data", {24'd0, dout_be}, 32'h33);
        check("t3_release_tready", {31'd0, tready_be}, 32'd0);
        @(negedge aclk);
        check("t3_final", {22'd0, valid_be, last_be, dout_be}, 32'h344);
        check("t3_final_tready", {31'd0, tready_be}, 32'd1);
        check("t3_err_clear", {31'd0, err_be}, 32'd0);
        @(posedge aclk);
        #1;

        // non-contiguous keep
        q_be.push_back({1'b1, 8'hDE});
        send_word(1'b0, 32'hDEADBEEF, 4'b1010, 1'b1, w);
        drop();
        @(negedge aclk);
        check("t4_err", {31'd0, err_be}, 32'd1);
        check("t4_byte", {22'd0, valid_be, last_be, dout_be}, 32'h3DE);
        @(posedge aclk);
        #1;

        // little-endian partial word
        q_le.push_back({1'b0, 8'hDD});
        q_le.push_back({1'b1, 8'hCC});
        send_word(1'b1, 32'hAABBCCDD, 4'b0011, 1'b1, w);
        drop();
        @(negedge aclk);
        check("t5_b0", {22'd0, valid_le, last_le, dout_le}, 32'h2DD);
        @(negedge aclk);
        check("t5_b1", {22'd0, valid_le, last_le, dout_le}, 32'h3CC);
        check("t5_le_err", {31'd0, err_le}, 32'd0);
        check("t4_err_sticky", {31'd0, err_be}, 32'd1);
        @(posedge aclk);
        #1;
        sel = 1'b0;

        // reset mid-packet
        q_be.push_back({1'b0, 8'hCA});
        q_be.push_back({1'b0, 8'hFE});
        send_word(1'b0, 32'hCAFEF00D, 4'b1111, 1'b1, w);
        drop();
        @(posedge aclk);
        #1;
        @(posedge aclk);
        #1 areset = 1'b1;
        @(negedge aclk);
        check("t6_async_valid", {31'd0, valid_be}, 32'd0);
        @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        check("t6_valid", {31'd0, valid_be}, 32'd0);
        check("t6_last", {31'd0, last_be}, 32'd0);
        check("t6_tready", {31'd0, tready_be}, 32'd1);
        check("t6_data", {24'd0, dout_be}, 32'd0);
        check("t6_err_cleared", {31'd0, err_be}, 32'd0);
        @(posedge aclk);
        #1;
        q_be.push_back({1'b0, 8'h0A});
        q_be.push_back({1'b0, 8'h0B});
        q_be.push_back({1'b0, 8'h0C});
        q_be.push_back({1'b1, 8'h0D});
        send_word(1'b0, 32'h0A0B0C0D, 4'b1111, 1'b1, w);
        drop();
        check("t6_restart_wait", w, 1);

        for (int i = 0; i < 100 && (q_be.size() != 0 || q_le.size() != 0); i++) begin
            @(posedge aclk);
        end
        repeat (3) @(posedge aclk);
        check("queues_drained", q_be.size() + q_le.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
